// File: rtl/rx_wb_capture.sv
// rx_wb_capture: multi-channel CIC I/Q capture into a 16-bit show-ahead FIFO.
// Optional group header/sequence words are enabled by RX_WB_CAPTURE_TAG_EN.
module rx_wb_capture #(
    parameter int NCH        = 4,
    parameter int IN_BITS    = 18,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                   adc_clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   in_strobe,
    input  logic [NCH*IN_BITS-1:0] in_i,
    input  logic [NCH*IN_BITS-1:0] in_q,
    input  logic [NCH-1:0]         ch_mask,
    input  logic                   mode_wide,
    input  logic                   rd_pop,
    output logic [15:0]            rd_dout,
    output logic                   rd_empty,
    output logic [DEPTH_LOG2:0]    words_avail,
    output logic [15:0]            ovfl_cnt,
    input  logic                   ovfl_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int GW    = 8;
    localparam int CW    = (DEPTH_LOG2 + 1 > GW) ? DEPTH_LOG2 + 1 : GW;

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_e;

    state_e                 state_q, state_d;
    logic [NCH*IN_BITS-1:0] si_q, si_d;
    logic [NCH*IN_BITS-1:0] sq_q, sq_d;
    logic [NCH-1:0]         rem_q, rem_d;
    logic                   wide_q, wide_d;
    logic [1:0]             wsel_q, wsel_d;
    logic [15:0]            ovfl_q, ovfl_d;
    logic [DEPTH_LOG2:0]    wptr_q, wptr_d;
    logic [DEPTH_LOG2:0]    rptr_q, rptr_d;
    logic [15:0]            mem_q [DEPTH];

    logic                   hdr_now;
`ifdef RX_WB_CAPTURE_TAG_EN
    logic [11:0]            seq_q, seq_d;
    logic [11:0]            hseq_q, hseq_d;
    logic                   hdr_q, hdr_d;
    assign hdr_now = hdr_q;
`else
    assign hdr_now = 1'b0;
`endif

    logic [DEPTH_LOG2:0]    count;
    logic [GW-1:0]          grp;
    logic [CW-1:0]          free_w;
    logic [CW-1:0]          grp_w;
    logic                   counted;
    logic                   accept;
    logic                   drop;
    logic                   pop_ok;
    logic                   wr_en;
    logic [15:0]            wr_data;
    logic                   last_word;
    logic [NCH-1:0]         cur_oh;
    logic [IN_BITS-1:0]     cur_i, cur_q;
    logic [23:0]            xi, xq;

    assign count       = wptr_q - rptr_q;
    assign words_avail = count;
    assign rd_empty    = (count == '0);
    assign rd_dout     = rd_empty ? 16'h0000 : mem_q[rptr_q[DEPTH_LOG2-1:0]];
    assign ovfl_cnt    = ovfl_q;
    assign pop_ok      = rd_pop && !rd_empty;
    assign counted     = in_strobe && enable;

    // Words the incoming group needs, judged on the live mask and mode.
    always_comb begin
        grp = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_mask[i]) begin
                grp = grp + (mode_wide ? GW'(3) : GW'(2));
            end
        end
`ifdef RX_WB_CAPTURE_TAG_EN
        grp = grp + GW'(1);
`endif
    end

    assign free_w = CW'(DEPTH) - CW'(count);
    assign grp_w  = CW'(grp);

    // Lowest pending channel wins; skipped channels cost no cycles.
    always_comb begin
        cur_oh = '0;
        cur_i  = '0;
        cur_q  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                cur_oh    = '0;
                cur_oh[i] = 1'b1;
                cur_i     = si_q[i*IN_BITS +: IN_BITS];
                cur_q     = sq_q[i*IN_BITS +: IN_BITS];
            end
        end
        xi = 24'(cur_i) << (24 - IN_BITS);
        xq = 24'(cur_q) << (24 - IN_BITS);
        wr_data   = 16'h0000;
        last_word = 1'b0;
        if (wide_q) begin
            case (wsel_q)
                2'd0:    wr_data = xi[15:0];
                2'd1:    wr_data = xq[15:0];
                default: wr_data = {xi[23:16], xq[23:16]};
            endcase
            last_word = (wsel_q == 2'd2);
        end else begin
            wr_data   = (wsel_q == 2'd0) ? xi[23:8] : xq[23:8];
            last_word = (wsel_q == 2'd1);
        end
`ifdef RX_WB_CAPTURE_TAG_EN
        if (hdr_q) begin
            wr_data = {4'hA, hseq_q};
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        si_d    = si_q;
        sq_d    = sq_q;
        rem_d   = rem_q;
        wide_d  = wide_q;
        wsel_d  = wsel_q;
        ovfl_d  = ovfl_q;
        accept  = 1'b0;
        drop    = 1'b0;
        wr_en   = 1'b0;
`ifdef RX_WB_CAPTURE_TAG_EN
        seq_d   = seq_q;
        hseq_d  = hseq_q;
        hdr_d   = hdr_q;
`endif
        if (counted) begin
            if (state_q == S_IDLE && free_w >= grp_w) begin
                accept = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    si_d   = in_i;
                    sq_d   = in_q;
                    rem_d  = ch_mask;
                    wide_d = mode_wide;
                    wsel_d = 2'd0;
`ifdef RX_WB_CAPTURE_TAG_EN
                    hdr_d   = 1'b1;
                    hseq_d  = seq_q;
                    state_d = S_EMIT;
`else
                    if (ch_mask != '0) begin
                        state_d = S_EMIT;
                    end
`endif
                end
            end
            S_EMIT: begin
                wr_en = 1'b1;
                if (hdr_now) begin
`ifdef RX_WB_CAPTURE_TAG_EN
                    hdr_d = 1'b0;
`endif
                    if (rem_q == '0) begin
                        state_d = S_IDLE;
                    end
                end else if (last_word) begin
                    wsel_d = 2'd0;
                    rem_d  = rem_q & ~cur_oh;
                    if (rem_d == '0) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    wsel_d = wsel_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clear beats a same-cycle drop.
        if (ovfl_clr) begin
            ovfl_d = 16'h0000;
        end else if (drop && ovfl_q != 16'hFFFF) begin
            ovfl_d = ovfl_q + 16'd1;
        end
`ifdef RX_WB_CAPTURE_TAG_EN
        if (counted) begin
            seq_d = seq_q + 12'd1;
        end
`endif
        wptr_d = wptr_q + {{DEPTH_LOG2{1'b0}}, wr_en};
        rptr_d = rptr_q + {{DEPTH_LOG2{1'b0}}, pop_ok};
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            si_q    <= '0;
            sq_q    <= '0;
            rem_q   <= '0;
            wide_q  <= 1'b0;
            wsel_q  <= 2'd0;
            ovfl_q  <= 16'h0000;
            wptr_q  <= '0;
            rptr_q  <= '0;
`ifdef RX_WB_CAPTURE_TAG_EN
            seq_q   <= 12'h000;
            hseq_q  <= 12'h000;
            hdr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            si_q    <= si_d;
            sq_q    <= sq_d;
            rem_q   <= rem_d;
            wide_q  <= wide_d;
            wsel_q  <= wsel_d;
            ovfl_q  <= ovfl_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
`ifdef RX_WB_CAPTURE_TAG_EN
            seq_q   <= seq_d;
            hseq_q  <= hseq_d;
            hdr_q   <= hdr_d;
`endif
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge adc_clk) begin
        if (wr_en) begin
            mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_rx_wb_capture.sv
// tb_rx_wb_capture: randomized and directed checks of rx_wb_capture against
// a queue-based reference model (honours RX_WB_CAPTURE_TAG_EN).
module tb_rx_wb_capture;

    localparam int NCH   = 4;
    localparam int IB    = 18;
    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;
`ifdef RX_WB_CAPTURE_TAG_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic              adc_clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              in_strobe;
    logic [NCH*IB-1:0] in_i;
    logic [NCH*IB-1:0] in_q;
    logic [NCH-1:0]    ch_mask;
    logic              mode_wide;
    logic              rd_pop;
    logic [15:0]       rd_dout;
    logic              rd_empty;
    logic [DL:0]       words_avail;
    logic [15:0]       ovfl_cnt;
    logic              ovfl_clr;

    int checks = 0;
    int errors = 0;

    logic [15:0] mf[$];
    logic [15:0] pend[$];
    int          m_ovfl;
    int          m_seq;

    always #5 adc_clk = ~adc_clk;

    rx_wb_capture #(
        .NCH(NCH),
        .IN_BITS(IB),
        .DEPTH_LOG2(DL)
    ) dut (
        .adc_clk(adc_clk),
        .reset_n(reset_n),
        .enable(enable),
        .in_strobe(in_strobe),
        .in_i(in_i),
        .in_q(in_q),
        .ch_mask(ch_mask),
        .mode_wide(mode_wide),
        .rd_pop(rd_pop),
        .rd_dout(rd_dout),
        .rd_empty(rd_empty),
        .words_avail(words_avail),
        .ovfl_cnt(ovfl_cnt),
        .ovfl_clr(ovfl_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] justify(input logic [IB-1:0] s);
        return 24'(s) * 24'(1 << (24 - IB));
    endfunction

    task automatic model_reset();
        mf.delete();
        pend.delete();
        m_ovfl = 0;
        m_seq  = 0;
    endtask

    task automatic build_group();
        logic [23:0] xi;
        logic [23:0] xq;
        if (HDR != 0) pend.push_back({4'hA, 12'(m_seq)});
        for (int n = 0; n < NCH; n++) begin
            if (ch_mask[n]) begin
                xi = justify(in_i[n*IB +: IB]);
                xq = justify(in_q[n*IB +: IB]);
                if (mode_wide) begin
                    pend.push_back(xi[15:0]);
                    pend.push_back(xq[15:0]);
                    pend.push_back({xi[23:16], xq[23:16]});
                end else begin
                    pend.push_back(xi[23:8]);
                    pend.push_back(xq[23:8]);
                end
            end
        end
    endtask

    // One clock edge of the reference: pending words drain one per edge.
    task automatic model_edge();
        int g;
        int free;
        bit busy;
        bit stb;
        bit acc;
        busy = (pend.size() != 0);
        free = DEPTH - mf.size();
        g    = $countones(ch_mask) * (mode_wide ? 3 : 2) + HDR;
        stb  = in_strobe && enable;
        acc  = stb && !busy && (free >= g);
        if (rd_pop && mf.size() != 0) void'(mf.pop_front());
        if (busy) mf.push_back(pend.pop_front());
        if (ovfl_clr) m_ovfl = 0;
        else if (stb && !acc && m_ovfl < 65535) m_ovfl++;
        if (acc) build_group();
        if (stb) m_seq = (m_seq + 1) % 4096;
    endtask

    task automatic compare(input string tag);
        check({tag, ".empty"}, 32'(rd_empty), 32'(mf.size() == 0));
        check({tag, ".avail"}, 32'(words_avail), 32'(mf.size()));
        check({tag, ".dout"}, 32'(rd_dout),
              (mf.size() != 0) ? 32'(mf[0]) : 32'h0);
        check({tag, ".ovfl"}, 32'(ovfl_cnt), 32'(m_ovfl));
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge adc_clk);
        #1;
        compare(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int k = 0; k < n; k++) cycle(tag);
    endtask

    task automatic rand_data();
        for (int n = 0; n < NCH; n++) begin
            in_i[n*IB +: IB] = IB'($urandom);
            in_q[n*IB +: IB] = IB'($urandom);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        in_strobe = 1'b0;
        in_i      = '0;
        in_q      = '0;
        ch_mask   = '0;
        mode_wide = 1'b0;
        rd_pop    = 1'b0;
        ovfl_clr  = 1'b0;
        model_reset();
        repeat (2) @(posedge adc_clk);
        #1;
        compare("reset");
        reset_n = 1'b1;
        run(2, "idle");

        // Wide, full mask, known channel-0 sample.
        enable    = 1'b1;
        mode_wide = 1'b1;
        ch_mask   = 4'hF;
        rand_data();
        in_i[17:0] = 18'h2ABCD;
        in_q[17:0] = 18'h15432;
        in_strobe = 1'b1;
        cycle("t1_acc");
        in_strobe = 1'b0;
        cycle("t1_e1");
        check("t1_first_avail", 32'(words_avail), 32'd1);
        run(14, "t1");
        check("t1_avail", 32'(words_avail), 32'(12 + HDR));

        // No room for a second group.
        rand_data();
        in_strobe = 1'b1;
        cycle("t1_drop");
        in_strobe = 1'b0;
        run(3, "t1_post");
        check("t1_ovfl", 32'(ovfl_cnt), 32'd1);
        check("t1_avail2", 32'(words_avail), 32'(12 + HDR));

        rd_pop = 1'b1;
        repeat (HDR) cycle("t1_hdr");
        check("t1_w0", 32'(rd_dout), 32'h0000F340);
        cycle("t1_p0");
        check("t1_w1", 32'(rd_dout), 32'h00000C80);
        cycle("t1_p1");
        check("t1_w2", 32'(rd_dout), 32'h0000AA55);
        run(14, "t1_drain");
        rd_pop = 1'b0;

        // Narrow mode, sparse mask.
        mode_wide = 1'b0;
        ch_mask   = 4'b0101;
        rand_data();
        in_i[2*IB +: IB] = 18'h3FFFF;
        in_q[2*IB +: IB] = 18'h00001;
        in_strobe = 1'b1;
        cycle("t2_acc");
        in_strobe = 1'b0;
        run(6, "t2");
        check("t2_avail", 32'(words_avail), 32'(4 + HDR));
        rd_pop = 1'b1;
        repeat (2 + HDR) cycle("t2_pop");
        check("t2_w2", 32'(rd_dout), 32'h0000FFFF);
        cycle("t2_p2");
        check("t2_w3", 32'(rd_dout), 32'h00000000);
        run(4, "t2_drain");

        // Back-to-back strobes every 4 cycles while popping.
        mode_wide = 1'b1;
        ch_mask   = 4'hF;
        for (int s = 0; s < 9; s++) begin
            rand_data();
            in_strobe = 1'b1;
            ovfl_clr  = (s == 1);
            cycle("t3_stb");
            in_strobe = 1'b0;
            if (s == 1) check("t3_clr", 32'(ovfl_cnt), 32'd0);
            ovfl_clr = 1'b0;
            run(3, "t3");
        end
        run(20, "t3_drain");

        // Empty mask, then an immediate follow-up strobe.
        ch_mask   = '0;
        in_strobe = 1'b1;
        cycle("t4_zero");
        ch_mask = 4'hF;
        rand_data();
        cycle("t4_next");
        in_strobe = 1'b0;
        run(20, "t4_drain");

        // Randomized traffic; wraps the pointers many times.
        for (int k = 0; k < 600; k++) begin
            rand_data();
            in_strobe = ($urandom_range(0, 4) == 0);
            enable    = ($urandom_range(0, 7) != 0);
            ch_mask   = NCH'($urandom);
            mode_wide = 1'($urandom);
            rd_pop    = ($urandom_range(0, 3) != 0);
            ovfl_clr  = ($urandom_range(0, 60) == 0);
            cycle("rand");
        end
        in_strobe = 1'b0;
        ovfl_clr  = 1'b0;
        enable    = 1'b1;
        rd_pop    = 1'b1;
        run(20, "rand_drain");
        rd_pop = 1'b0;

        // Make ovfl nonzero, then reset in the middle of a group.
        ch_mask   = 4'hF;
        mode_wide = 1'b1;
        rand_data();
        in_strobe = 1'b1;
        cycle("t5_acc");
        cycle("t5_drop");
        in_strobe = 1'b0;
        run(4, "t5");
        reset_n = 1'b0;
        #1;
        model_reset();
        check("t5_rst_empty", 32'(rd_empty), 32'd1);
        check("t5_rst_avail", 32'(words_avail), 32'd0);
        check("t5_rst_ovfl", 32'(ovfl_cnt), 32'd0);
        @(posedge adc_clk);
        #1;
        reset_n = 1'b1;
        compare("t5_rel");
        rand_data();
        in_strobe = 1'b1;
        cycle("t5_acc2");
        in_strobe = 1'b0;
        run(14, "t5_fill");
        check("t5_avail", 32'(words_avail), 32'(12 + HDR));
`ifdef RX_WB_CAPTURE_TAG_EN
        check("t5_hdr", 32'(rd_dout), 32'h0000A000);
`endif
        rd_pop = 1'b1;
        run(16, "t5_drain");
        rd_pop = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
